// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: MEM-stage load/store request/response bus between core and data memory.
//   master (core):      drives reqValid/reqWrite/reqAddr/reqWdata/reqBe/rspReady,
//                       receives reqReady/rspValid/rspRdata/rspErr
//   slave  (responder): the mirror image
//   reqAddr is a byte address; reqBe bit i enables byte lane [8i+7:8i] of a store.
interface data_mem_responder_if;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [3:0]  reqBe;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;
    modport master (
        output reqValid, reqWrite, reqAddr, reqWdata, reqBe, rspReady,
        input  reqReady, rspValid, rspRdata, rspErr
    );
    modport slave (
        input  reqValid, reqWrite, reqAddr, reqWdata, reqBe, rspReady,
        output reqReady, rspValid, rspRdata, rspErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory answering MEM-stage loads/stores with programmable wait states.
//   CLK      in  clock, rising edge
//   RESET_N  in  asynchronous active-low reset (memory contents are kept)
//   bus      slave side of data_mem_responder_if (one request at a time, held response)
//   Optional feature macro MEM_DUMP_EN adds a full-memory dump port:
//     dumpReq in, dumpValid/dumpAddr/dumpData/dumpDone out.
//   Every access is answered WAIT_CYCLES+1 edges after acceptance (accepting edge included).
//   Misaligned or out-of-range addresses return rspErr=1, rspRdata=0 and never write.
module data_mem_responder #(
    parameter int DEPTH       = 512,
    parameter int ADDR_W      = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
`ifdef MEM_DUMP_EN
    input  logic                  dumpReq,
    output logic                  dumpValid,
    output logic [ADDR_W-1:0]     dumpAddr,
    output logic [31:0]           dumpData,
    output logic                  dumpDone,
`endif
    data_mem_responder_if.slave   bus
);
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

`ifdef MEM_DUMP_EN
    typedef enum logic [1:0] {IDLE, WAIT, RESP, DUMP} stateT;
    logic [ADDR_W:0] dumpCnt;
`else
    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;
`endif

    stateT       state, nextState;
    logic [31:0] mem [DEPTH];
    logic        latWrite;
    logic [31:0] latAddr, latWdata;
    logic [3:0]  latBe;
    logic [3:0]  waitCnt;
    logic [31:0] rspRdata;
    logic        rspErr;
    logic        dumpGo, accept, enterResp, doWrite;
    logic        curWrite, curErr;
    logic [31:0] curAddr, curWdata, oldWord, newWord;
    logic [3:0]  curBe;
    logic [ADDR_W-1:0] curIdx;

`ifdef MEM_DUMP_EN
    assign dumpGo = dumpReq;
`else
    assign dumpGo = 1'b0;
`endif

    // A dump request in IDLE takes priority, so the bus request is not accepted that cycle.
    assign accept = (state == IDLE) && bus.reqValid && !dumpGo;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
`ifdef MEM_DUMP_EN
                if (dumpGo) nextState = DUMP;
                else
`endif
                if (bus.reqValid) nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
            end
            WAIT:    nextState = (waitCnt == LAST_WAIT) ? RESP : WAIT;
            RESP:    nextState = bus.rspReady ? IDLE : RESP;
`ifdef MEM_DUMP_EN
            DUMP:    nextState = dumpCnt[ADDR_W] ? IDLE : DUMP;
`endif
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        bus.reqReady = (state == IDLE) && RESET_N && !dumpGo;
        bus.rspValid = (state == RESP);
        bus.rspRdata = rspRdata;
        bus.rspErr   = rspErr;
`ifdef MEM_DUMP_EN
        dumpValid = (state == DUMP) && !dumpCnt[ADDR_W];
        dumpDone  = (state == DUMP) && dumpCnt[ADDR_W];
        dumpAddr  = dumpValid ? dumpCnt[ADDR_W-1:0] : '0;
        dumpData  = dumpValid ? mem[dumpCnt[ADDR_W-1:0]] : '0;
`endif
    end

    // With zero wait states the commit edge is also the accepting edge, so the
    // access is taken straight from the bus instead of the latched copy.
    assign enterResp = (nextState == RESP) && (state != RESP);
    assign curWrite  = (state == IDLE) ? bus.reqWrite : latWrite;
    assign curAddr   = (state == IDLE) ? bus.reqAddr  : latAddr;
    assign curWdata  = (state == IDLE) ? bus.reqWdata : latWdata;
    assign curBe     = (state == IDLE) ? bus.reqBe    : latBe;
    assign curIdx    = curAddr[ADDR_W+1:2];
    assign curErr    = (curAddr[1:0] != 2'b0) || (curAddr[31:ADDR_W+2] != '0);
    assign oldWord   = mem[curIdx];
    // RESET_N gate keeps a request presented during reset from writing memory.
    assign doWrite   = enterResp && curWrite && !curErr && RESET_N;

    always_comb begin
        newWord = oldWord;
        for (int i = 0; i < 4; i++)
            if (curBe[i]) newWord[8*i +: 8] = curWdata[8*i +: 8];
    end

    always_ff @(posedge CLK) begin
        if (doWrite) mem[curIdx] <= newWord;
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            latWrite <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
            latBe    <= '0;
            waitCnt  <= '0;
            rspRdata <= '0;
            rspErr   <= 1'b0;
`ifdef MEM_DUMP_EN
            dumpCnt  <= '0;
`endif
        end else begin
            if (accept) begin
                latWrite <= bus.reqWrite;
                latAddr  <= bus.reqAddr;
                latWdata <= bus.reqWdata;
                latBe    <= bus.reqBe;
            end
            waitCnt <= (state == WAIT && nextState == WAIT) ? waitCnt + 4'd1 : 4'd0;
            if (enterResp) begin
                rspRdata <= curErr ? 32'h0 : (curWrite ? newWord : oldWord);
                rspErr   <= curErr;
            end
`ifdef MEM_DUMP_EN
            dumpCnt <= (state == DUMP) ? dumpCnt + 1'b1 : '0;
`endif
        end
    end
endmodule
